// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode encodings, instruction field widths and
// the packed instruction layout used by fetch, decode and the program loader.
package isa_pkg;

  localparam int INSTR_W        = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = INSTR_W / BYTE_W;
  localparam int OPC_W          = 7;
  localparam int REG_W          = 5;
  localparam int IMM_W          = 15;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 7'h00,
    OP_ADD = 7'h01,
    OP_SUB = 7'h02,
    OP_AND = 7'h03,
    OP_OR  = 7'h04,
    OP_XOR = 7'h05,
    OP_SHL = 7'h06,
    OP_SHR = 7'h07,
    OP_LDI = 7'h08,
    OP_LD  = 7'h09,
    OP_ST  = 7'h0a,
    OP_BEQ = 7'h0b,
    OP_BNE = 7'h0c,
    OP_JMP = 7'h0d,
    OP_JML = 7'h0e
  } opcode_e;

  // Opcode sits in the MSBs, so the first byte streamed in carries it.
  typedef struct packed {
    opcode_e            opc;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [IMM_W-1:0]   imm;
  } instr_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader link bundle: incoming byte stream (valid/ready) plus the
// program-memory write port driven by the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/byte_packer.sv
// Packs a big-endian byte stream into 32-bit words; flags the accept
// that completes a word and exposes the word including that last byte.
module byte_packer
  import isa_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_accept,
  input  logic [BYTE_W-1:0]  i_byte,
  output logic               o_word_valid,
  output logic [INSTR_W-1:0] o_word
);

  logic [1:0]         r_idx;
  logic [INSTR_W-1:0] r_word;
  logic [INSTR_W-1:0] w_merged;

  always_comb begin
    w_merged = r_word;
    case (r_idx)
      2'd0:    w_merged[31:24] = i_byte;
      2'd1:    w_merged[23:16] = i_byte;
      2'd2:    w_merged[15:8]  = i_byte;
      default: w_merged[7:0]   = i_byte;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      r_idx  <= r_idx + 2'd1;
      r_word <= w_merged;
    end
  end

  assign o_word_valid = i_accept & (r_idx == 2'd3);
  assign o_word       = w_merged;

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory one packed word at a
// time, holding the CPU for the whole load.
module imem_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = INSTR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [ADDR_W:0]  i_load_len,
  input  logic             i_abort,
  imem_loader_if.slave     bus,
  output logic             o_cpu_hold,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_e;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_e              r_state;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_count;
  logic                r_ready;
  logic                r_we;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_accept;
  logic                w_clear;
  logic                w_word_valid;
  logic [INSTR_W-1:0]  w_word;
  logic [ADDR_W:0]     w_len_clamped;
  logic [ADDR_W:0]     w_count_inc;

  assign w_accept      = bus.in_valid & r_ready;
  assign w_clear       = i_abort | ((r_state == S_IDLE) & i_start);
  assign w_len_clamped = (i_load_len > MAX_LEN) ? MAX_LEN : i_load_len;
  assign w_count_inc   = r_count + 1'b1;

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_accept     (w_accept),
    .i_byte       (bus.in_byte),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_len   <= w_len_clamped;
            r_count <= '0;
            r_busy  <= 1'b1;
            if (w_len_clamped == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RECV;
              r_ready <= 1'b1;
            end
          end
        end
        S_RECV: begin
          // Abort beats a word-completing byte: nothing gets written.
          if (i_abort) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_word_valid) begin
            r_state <= S_WRITE;
            r_ready <= 1'b0;
            r_we    <= 1'b1;
            r_addr  <= r_count[ADDR_W-1:0];
            r_wdata <= w_word;
          end
        end
        S_WRITE: begin
          r_count <= w_count_inc;
          if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_count_inc < r_len) begin
            r_state <= S_RECV;
            r_ready <= 1'b1;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_ready;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign o_busy        = r_busy;
  assign o_cpu_hold    = r_busy;
  assign o_done        = r_done;

endmodule
